mips_prog_loader: RTL and testbench

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

---
 rtl/mips_pkg.sv | 16 +
 rtl/mips_prog_loader.sv | 175 +++++++++++++++++
 tb/tb_mips_prog_loader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS program loader:
// loader FSM state type, HLT opcode and default instruction-memory width.
package mips_pkg;

    localparam int          DEFAULT_ADDR_W = 10;
    localparam logic [31:0] HLT_OPCODE     = 32'hfc000000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/mips_prog_loader.sv
// mips_prog_loader -- streams a program into the MIPS32 instruction memory
// over a valid/ready handshake, then releases the CPU and waits for HLT.
// Optional feature: define LOADER_CHECKSUM_EN to expect an XOR checksum word
// after the in_last word; a mismatch aborts into ERR instead of RUN.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    input  logic              cpu_halted,
    input  logic              restart,
    output logic              done,
    output logic              err
);

    // One spare bit so the count can represent DEPTH itself.
    localparam int CNT_W = $clog2(DEPTH + 1);

    loader_state_t     r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_run;
    logic              r_done;
    logic              r_err;
    logic              r_finish;   // in_last word is being written; RUN next
    logic [1:0]        r_run_cnt;  // masks cpu_halted while it is still stale
`ifdef LOADER_CHECKSUM_EN
    logic              r_await_csum;
    logic [31:0]       r_xor;
`endif

    logic              w_accept;
    logic              w_overflow;
    logic [ADDR_W-1:0] w_wr_addr;

    // Handshake, overflow detect and write address (wraps modulo 2^ADDR_W).
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        w_accept   = in_valid && r_in_ready;
        w_overflow = (r_count == CNT_W'(DEPTH));
        w_wr_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(r_count);
    end

    // Loader FSM with all outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= ADDR_W'(BASE_ADDR);
            r_mem_wdata  <= '0;
            r_cpu_run    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_finish     <= 1'b0;
            r_run_cnt    <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_await_csum <= 1'b0;
            r_xor        <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE, LOAD: begin
                    if (r_finish) begin
                        // Final write was presented last cycle; release the CPU.
                        r_finish  <= 1'b0;
                        r_state   <= RUN;
                        r_cpu_run <= 1'b1;
                        r_run_cnt <= '0;
                    end else if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
                        if (r_await_csum) begin
                            // Checksum word: compared, never written.
                            r_await_csum <= 1'b0;
                            r_in_ready   <= 1'b0;
                            if (in_data == r_xor) begin
                                r_state   <= RUN;
                                r_cpu_run <= 1'b1;
                                r_run_cnt <= '0;
                            end else begin
                                r_state <= ERR;
                                r_err   <= 1'b1;
                            end
                        end else
`endif
                        if (w_overflow && !in_last) begin
                            r_state    <= ERR;
                            r_err      <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= in_data;
                            r_mem_addr  <= w_wr_addr;
                            r_count     <= r_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            r_xor       <= r_xor ^ in_data;
                            r_state     <= LOAD;
                            if (in_last) begin
                                r_await_csum <= 1'b1;
                            end
`else
                            if (in_last) begin
                                r_finish   <= 1'b1;
                                r_in_ready <= 1'b0;
                            end else begin
                                r_state <= LOAD;
                            end
`endif
                        end
                    end else begin
                        // Covers the first edge after reset release.
                        r_in_ready <= 1'b1;
                    end
                end

                RUN: begin
                    if (r_run_cnt != 2'd2) begin
                        r_run_cnt <= r_run_cnt + 2'd1;
                    end else if (cpu_halted) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_cpu_run <= 1'b0;
                    end
                end

                DONE, ERR: begin
                    if (restart) begin
                        r_state      <= IDLE;
                        r_count      <= '0;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_in_ready   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_await_csum <= 1'b0;
                        r_xor        <= '0;
`endif
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_cpu_run  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_run   = r_cpu_run;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader -- directed bench for mips_prog_loader. Build with
// LOADER_CHECKSUM_EN defined to exercise the checksum variant instead of
// the plain load/run sequences; the DEPTH=4 overflow case runs in both.
module tb_mips_prog_loader;
    import mips_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        cpu_halted = 1'b0;
    logic        restart = 1'b0;
    logic        in_ready, mem_we, cpu_run, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic        o_in_valid = 1'b0;
    logic [31:0] o_in_data = '0;
    logic        o_in_last = 1'b0;
    logic        o_in_ready, o_mem_we, o_cpu_run, o_done, o_err;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovf_writes = 0;

    logic [9:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    // Factorial program, Mem[0..10], ending in HLT.
    logic [31:0] prog [11] = '{
        32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
        32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
        32'h3460fffc, 32'h2542fffe, 32'hfc000000
    };

    mips_prog_loader u_dut (
        .clk1(clk1), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .cpu_halted(cpu_halted), .restart(restart),
        .done(done), .err(err)
    );

    mips_prog_loader #(.DEPTH(4)) u_ovf (
        .clk1(clk1), .rst_n(rst_n),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data), .in_last(o_in_last),
        .mem_we(o_mem_we), .mem_addr(o_mem_addr), .mem_wdata(o_mem_wdata),
        .cpu_run(o_cpu_run), .cpu_halted(cpu_halted), .restart(restart),
        .done(o_done), .err(o_err)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc++;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_cyc.push_back(cyc);
        end
        if (o_mem_we === 1'b1) ovf_writes++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Back-to-back load of the whole program, checking each write as it appears.
    task automatic load_b2b(input string tag);
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_data  = prog[i];
            in_last  = (i == 10);
            tick();
            check($sformatf("%s_we[%0d]", tag, i), 32'(mem_we), 32'd1);
            check($sformatf("%s_addr[%0d]", tag, i), 32'(mem_addr), 32'(i));
            check($sformatf("%s_data[%0d]", tag, i), mem_wdata, prog[i]);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_write_log(input string tag, input int spacing);
        check({tag, "_count"}, 32'(wq_addr.size()), 32'd11);
        if (wq_addr.size() == 11) begin
            for (int i = 0; i < 11; i++) begin
                check($sformatf("%s_log_addr[%0d]", tag, i), 32'(wq_addr[i]), 32'(i));
                check($sformatf("%s_log_data[%0d]", tag, i), wq_data[i], prog[i]);
                check($sformatf("%s_log_cyc[%0d]", tag, i), 32'(wq_cyc[i] - wq_cyc[0]), 32'(i * spacing));
            end
        end
    endtask

    task automatic halt_and_restart(input string tag);
        int n;
        cpu_halted = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cpu_halted = 1'b0;
        check({tag, "_restart_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_restart_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] csum;
        int n;

        // Reset state, and in_ready rising on the first edge after release.
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        check("in_ready_after_edge", 32'(in_ready), 32'd1);

`ifndef LOADER_CHECKSUM_EN
        // Back-to-back factorial load, then RUN the cycle after the HLT write.
        clear_writes();
        load_b2b("b2b");
        check("b2b_in_ready_last", 32'(in_ready), 32'd0);
        check("b2b_run_during_last", 32'(cpu_run), 32'd0);
        tick();
        check("b2b_cpu_run", 32'(cpu_run), 32'd1);
        check("b2b_we_idle", 32'(mem_we), 32'd0);
        check_write_log("b2b", 1);

        // Restart is ignored in RUN; cpu_halted arrives 50 cycles into RUN.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("run_ignores_restart", 32'(cpu_run), 32'd1);
        for (int i = 0; i < 48; i++) tick();
        check("run_held_49", 32'(cpu_run), 32'd1);
        check("run_not_done_49", 32'(done), 32'd0);
        cpu_halted = 1'b1;
        tick();
        check("halt_done", 32'(done), 32'd1);
        check("halt_cpu_run", 32'(cpu_run), 32'd0);
        check("halt_in_ready", 32'(in_ready), 32'd0);
        cpu_halted = 1'b0;
        tick();
        check("done_sticky", 32'(done), 32'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_in_ready", 32'(in_ready), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_err", 32'(err), 32'd0);

        // in_valid toggling every other cycle: 11 writes, two cycles apart.
        clear_writes();
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_data  = prog[i];
            in_last  = (i == 10);
            tick();
            in_valid = 1'b0;
            in_data  = 32'hdeadbeef;
            in_last  = 1'b0;
            tick();
        end
        n = 0;
        while (cpu_run !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("toggle_cpu_run", 32'(cpu_run), 32'd1);
        check_write_log("toggle", 2);
        halt_and_restart("toggle");

        // Reset pulled after 5 of 11 words; reload restarts at address 0.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = prog[i];
            tick();
        end
        check("mid_we_before_reset", 32'(mem_we), 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        clear_writes();
        load_b2b("reload");
        tick();
        check("reload_cpu_run", 32'(cpu_run), 32'd1);
        check_write_log("reload", 1);
        halt_and_restart("reload");

        // Single-word program with cpu_halted already high: two masked RUN cycles.
        cpu_halted = 1'b1;
        in_valid = 1'b1;
        in_data  = HLT_OPCODE;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("single_we", 32'(mem_we), 32'd1);
        check("single_addr", 32'(mem_addr), 32'd0);
        check("single_data", mem_wdata, 32'hfc000000);
        tick();
        check("single_run_c1", 32'(cpu_run), 32'd1);
        tick();
        check("single_run_c2", 32'(cpu_run), 32'd1);
        check("single_done_c2", 32'(done), 32'd0);
        tick();
        check("single_run_c3", 32'(cpu_run), 32'd1);
        check("single_done_c3", 32'(done), 32'd0);
        tick();
        check("single_done", 32'(done), 32'd1);
        check("single_run_off", 32'(cpu_run), 32'd0);
        cpu_halted = 1'b0;
`else
        // Correct XOR checksum: 11 writes, checksum not written, then RUN.
        csum = '0;
        for (int i = 0; i < 11; i++) csum = csum ^ prog[i];
        clear_writes();
        load_b2b("csum_ok");
        check("csum_ok_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = csum;
        tick();
        in_valid = 1'b0;
        check("csum_ok_cpu_run", 32'(cpu_run), 32'd1);
        check("csum_ok_no_write", 32'(mem_we), 32'd0);
        check("csum_ok_err", 32'(err), 32'd0);
        tick();
        check_write_log("csum_ok", 1);
        halt_and_restart("csum_ok");

        // Checksum XOR 1: 11 writes, then ERR.
        clear_writes();
        load_b2b("csum_bad");
        in_valid = 1'b1;
        in_data  = csum ^ 32'd1;
        tick();
        in_valid = 1'b0;
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_cpu_run", 32'(cpu_run), 32'd0);
        check("csum_bad_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_write_log("csum_bad", 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("csum_bad_restart_err", 32'(err), 32'd0);
        check("csum_bad_restart_ready", 32'(in_ready), 32'd1);
`endif

        // DEPTH=4 instance: 5 words without in_last -> 4 writes then ERR.
        check("ovf_in_ready", 32'(o_in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            o_in_valid = 1'b1;
            o_in_data  = prog[i];
            tick();
            check($sformatf("ovf_we[%0d]", i), 32'(o_mem_we), 32'd1);
            check($sformatf("ovf_addr[%0d]", i), 32'(o_mem_addr), 32'(i));
        end
        o_in_data = prog[4];
        tick();
        o_in_valid = 1'b0;
        check("ovf_5th_we", 32'(o_mem_we), 32'd0);
        check("ovf_err", 32'(o_err), 32'd1);
        check("ovf_in_ready_low", 32'(o_in_ready), 32'd0);
        check("ovf_cpu_run", 32'(o_cpu_run), 32'd0);
        tick();
        check("ovf_err_sticky", 32'(o_err), 32'd1);
        check("ovf_write_count", 32'(ovf_writes), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
